// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch packets between next-PC and decode.
// Each entry holds a fetch PC, two 32-bit instruction slots and a slot mask.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a packet
// arriving at an empty queue is presented on deq_* in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  input  logic [31:0]                enq_pc_i,
  input  logic [63:0]                enq_inst_i,
  output logic                       enq_ready_o,
  output logic                       deq_valid_o,
  output logic [31:0]                deq_pc_o,
  output logic [63:0]                deq_inst_o,
  output logic [1:0]                 deq_slot_valid_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage is deliberately left unreset; outputs are masked when empty.
  logic [31:0] pc_mem_q   [DEPTH];
  logic [63:0] inst_mem_q [DEPTH];
  logic [1:0]  mask_mem_q [DEPTH];

  logic empty;
  logic bypass;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;
  logic rd_adv;
  logic [1:0] enq_mask;

  assign empty       = (count_q == '0);
  assign enq_ready_o = (count_q < FULL_CNT);
  assign count_o     = count_q;

  // Slot 0 sits before a fetch PC with bit 2 set, so it is not a real instruction.
  assign enq_mask = {1'b1, ~enq_pc_i[2]};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && enq_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid_o = !empty || bypass;
  assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;
  // A bypassed packet consumed in its arrival cycle never touches storage.
  assign wr_en       = enq_fire && !(bypass && deq_ready_i);
  assign rd_adv      = deq_fire && !empty;

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]   <= enq_pc_i;
      inst_mem_q[wr_ptr_q] <= enq_inst_i;
      mask_mem_q[wr_ptr_q] <= enq_mask;
    end
  end

  // Head outputs: stored head, else the bypassed packet, else zero.
  always_comb begin
    deq_pc_o         = '0;
    deq_inst_o       = '0;
    deq_slot_valid_o = '0;
    if (!empty) begin
      deq_pc_o         = pc_mem_q[rd_ptr_q];
      deq_inst_o       = inst_mem_q[rd_ptr_q];
      deq_slot_valid_o = mask_mem_q[rd_ptr_q];
    end else if (bypass) begin
      deq_pc_o         = enq_pc_i;
      deq_inst_o       = enq_inst_i;
      deq_slot_valid_o = enq_mask;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the next-PC generator and the decoder. Accepts one aligned 8-byte fetch packet per cycle (two instruction slots, tagged with its fetch PC), buffers up to `DEPTH` packets in a circular FIFO, and presents the oldest packet to decode with a per-slot valid mask. It generates the backpressure that stalls the PC register and drops all buffered packets on a pipeline flush.

## Interface
- `DEPTH`, default 4: number of packet entries; power of two, ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `flush_i`  in  1: redirect from the backend (same signal that retargets the PC); discards queue contents.
- `enq_valid_i`  in  1: fetch packet available this cycle.
- `enq_pc_i`  in  32: fetch PC of the packet; bit 2 selects the starting slot.
- `enq_inst_i`  in  64: `[31:0]` is slot 0 (PC bits 2..0 = 000), `[63:32]` is slot 1 (PC bits 2..0 = 100).
- `enq_ready_o`  out  1: queue can accept a packet. It is driven straight into the PC stage's stall input as its inverse.
- `deq_valid_o`  out  1: head packet valid.
- `deq_pc_o`  out  32: head packet fetch PC, passed through unmodified.
- `deq_inst_o`  out  64: head packet instructions.
- `deq_slot_valid_o`  out  2: bit 0 = slot 0 holds a real instruction, bit 1 = slot 1 does.
- `deq_ready_i`  in  1: decode consumes the head packet this cycle.
- `count_o`  out  $clog2(DEPTH)+1: current occupancy, for debug.

## Operation
- Storage is a circular buffer with:
  - a write pointer and a read pointer, each $clog2(DEPTH) bits, wrapping naturally at DEPTH;
  - an occupancy counter of $clog2(DEPTH)+1 bits.
- Enqueue fires when `enq_valid_i && enq_ready_o && !flush_i`. The entry stores the PC, the instructions and a slot mask:
  - `enq_pc_i[2]==0` gives mask 2'b11;
  - `enq_pc_i[2]==1` gives mask 2'b10 (slot 0 lies before the fetch PC and is dropped).
- Dequeue fires when `deq_valid_o && deq_ready_i && !flush_i`; the read pointer advances by one.
- `enq_ready_o = (count < DEPTH)`. It does not depend on `deq_ready_i`, so there is no combinational path from decode to the PC stage.
- Occupancy update:
  - enqueue only: +1;
  - dequeue only: −1;
  - both in the same cycle: unchanged, with both pointers advancing.
- `deq_valid_o = (count != 0)`. The head outputs come from the entry at the read pointer.
- Flush has priority over everything. Pointers and count clear to 0 at the next edge, and any enqueue or dequeue presented in the flush cycle is discarded. The packet arriving the cycle after flush (the redirect target) is accepted normally.
- Boundary behaviour:
  - Full: `enq_ready_o`=0. An `enq_valid_i` held high is ignored and the producer must hold the packet. A simultaneous dequeue frees a slot, visible the next cycle.
  - Empty: `deq_valid_o`=0. `deq_ready_i` is ignored.
  - Wrap: pointer DEPTH−1 increments to 0.
- Reset, including mid-operation: count=0, pointers=0, `deq_valid_o`=0, `enq_ready_o`=1, `deq_slot_valid_o`=0, `deq_pc_o`/`deq_inst_o`=0. Entry storage need not be reset; outputs are masked to 0 when empty.

## Timing
- Without bypass: an enqueue at edge N becomes visible on `deq_*` after edge N, so there is 1 cycle of latency from `enq_valid_i` to `deq_valid_o`.
- `enq_ready_o` and `deq_valid_o` are functions of registered state only.
- Flush at edge N: `deq_valid_o`=0 and `enq_ready_o`=1 from cycle N+1.
- Throughput: one packet in and one packet out per cycle in steady state.

## Configuration
- Macro: `FETCH_QUEUE_BYPASS_EN`.
- Defined: when the queue is empty and an enqueue fires, the incoming packet is driven combinationally onto `deq_*` in the same cycle, giving 0-cycle latency.
  - If `deq_ready_i` is also high, the packet is consumed and is not written (count stays 0).
  - Otherwise it is written as normal.
  - Flush still suppresses both.
- Undefined: no bypass path; `deq_*` depends only on registered state, as described in Timing.

## Test plan
- Reset, then enqueue PC 0x1c00_0000 with inst 0x00000002_00000001 → the next cycle shows `deq_valid_o`=1, `deq_pc_o`=0x1c00_0000, `deq_slot_valid_o`=2'b11. With bypass: the same values appear in the enqueue cycle.
- Enqueue PC 0x1c00_0004 → `deq_slot_valid_o`=2'b10, and `deq_inst_o[63:32]` equals the enqueued upper word.
- Hold `deq_ready_i`=0 and enqueue 5 packets with DEPTH=4 → `enq_ready_o`=0 after the 4th; the 5th is held, then accepted the cycle after one dequeue. Order is preserved across the pointer wrap.
- With the queue at 3 entries, assert `flush_i` together with `enq_valid_i` and `deq_ready_i` → the next cycle has count=0 and `deq_valid_o`=0. Enqueue target 0x1c00_0100 → it appears as the head, and no stale entries remain.
- Continuous enqueue and dequeue for 20 cycles at 8-byte PC increments → count stays constant and every PC appears once, in order.
- Assert `rst_n`=0 asynchronously while 2 entries are queued → outputs go to their reset values immediately, without waiting for a clock edge.
